// File: rtl/phy_regfile_wb_arbiter.sv
// phy_regfile_wb_arbiter: buffers results from two execution units,
// drains one per cycle to the register file and tracks ready bits.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   fuN_valid/ready  per-unit result handshake (N = 0, 1)
//   fuN_dst_reg/val  destination physical register and result value
//   fuN_reg_wb       result writes a register (else dropped)
//   alloc_en/reg     rename allocation, clears the ready bit
//   query_regK/rdyK  combinational ready-bit lookups (K = 1, 2)
//   commit_wr_*      registered register-file write port
//   pending_cnt      entries held across both FIFOs
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

module phy_regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int VAL_WIDTH  = `REG_VAL_WIDTH,
  parameter int PREG_WIDTH = `PHYSICAL_REG_NUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fu0_valid,
  output logic                  fu0_ready,
  input  logic [PREG_WIDTH-1:0] fu0_dst_reg,
  input  logic [VAL_WIDTH-1:0]  fu0_val,
  input  logic                  fu0_reg_wb,
  input  logic                  fu1_valid,
  output logic                  fu1_ready,
  input  logic [PREG_WIDTH-1:0] fu1_dst_reg,
  input  logic [VAL_WIDTH-1:0]  fu1_val,
  input  logic                  fu1_reg_wb,
  input  logic                  alloc_en,
  input  logic [PREG_WIDTH-1:0] alloc_reg,
  input  logic [PREG_WIDTH-1:0] query_reg1,
  input  logic [PREG_WIDTH-1:0] query_reg2,
  output logic                  query_rdy1,
  output logic                  query_rdy2,
  output logic                  commit_wr_en,
  output logic [PREG_WIDTH-1:0] wr_commit_reg,
  output logic [VAL_WIDTH-1:0]  commit_wr_val,
  output logic [$clog2(2*FIFO_DEPTH+1)-1:0] pending_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(2*FIFO_DEPTH + 1);
  localparam int NREG = 1 << PREG_WIDTH;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  // Unit inputs gathered into arrays so both FIFOs share one body.
  logic                  in_valid [2];
  logic [PREG_WIDTH-1:0] in_dst   [2];
  logic [VAL_WIDTH-1:0]  in_val   [2];
  logic                  in_wb    [2];

  logic [PREG_WIDTH-1:0] q_reg [2][FIFO_DEPTH];
  logic [VAL_WIDTH-1:0]  q_val [2][FIFO_DEPTH];
  logic [AW-1:0]         wptr  [2];
  logic [AW-1:0]         rptr  [2];
  logic [OW-1:0]         occ   [2];
  logic [OW-1:0]         occ_nxt [2];

  logic                  full   [2];
  logic                  nempty [2];
  logic                  push   [2];
  logic [1:0]            gnt;
  logic                  gsel;
  logic                  rr;

  logic [PREG_WIDTH-1:0] head_reg;
  logic [VAL_WIDTH-1:0]  head_val;

  logic [NREG-1:0]       rdy_map;
  logic [NREG-1:0]       rdy_nxt;

  always_comb begin
    in_valid[0] = fu0_valid;
    in_dst[0]   = fu0_dst_reg;
    in_val[0]   = fu0_val;
    in_wb[0]    = fu0_reg_wb;
    in_valid[1] = fu1_valid;
    in_dst[1]   = fu1_dst_reg;
    in_val[1]   = fu1_val;
    in_wb[1]    = fu1_reg_wb;
  end

  // Ready comes only from occupancy; a same-cycle pop does not
  // free a slot until the next cycle.  Results with no register
  // destination are accepted but never stored.
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      full[u]   = (occ[u] == OCC_FULL);
      nempty[u] = (occ[u] != '0);
      push[u]   = in_valid[u] && !full[u] &&
                  in_wb[u] && (in_dst[u] != '0);
    end
  end

  assign fu0_ready = !full[0];
  assign fu1_ready = !full[1];

  // Round-robin only matters when both FIFOs hold data.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      nempty[0] && nempty[1]:  gnt[rr] = 1'b1;
      nempty[0] && !nempty[1]: gnt[0]  = 1'b1;
      !nempty[0] && nempty[1]: gnt[1]  = 1'b1;
      default:                 gnt     = 2'b00;
    endcase
  end

  assign gsel     = gnt[1];
  assign head_reg = q_reg[gsel][rptr[gsel]];
  assign head_val = q_val[gsel][rptr[gsel]];

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      unique case ({push[u], gnt[u]})
        2'b10:   occ_nxt[u] = occ[u] + OCC_ONE;
        2'b01:   occ_nxt[u] = occ[u] - OCC_ONE;
        default: occ_nxt[u] = occ[u];
      endcase
    end
  end

  // Storage is not reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (push[u]) begin
        q_reg[u][wptr[u]] <= in_dst[u];
        q_val[u][wptr[u]] <= in_val[u];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        wptr[u] <= '0;
        rptr[u] <= '0;
        occ[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (push[u]) wptr[u] <= wptr[u] + PTR_ONE;
        if (gnt[u])  rptr[u] <= rptr[u] + PTR_ONE;
        occ[u] <= occ_nxt[u];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (gnt[0]) begin
      rr <= 1'b1;
    end else if (gnt[1]) begin
      rr <= 1'b0;
    end
  end

  // Index and value hold on idle cycles; only the enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_wr_en  <= 1'b0;
      wr_commit_reg <= '0;
      commit_wr_val <= '0;
    end else begin
      commit_wr_en <= |gnt;
      if (|gnt) begin
        wr_commit_reg <= head_reg;
        commit_wr_val <= head_val;
      end
    end
  end

  // Tracks occupancy after this edge so the count matches the FIFOs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_cnt <= '0;
    end else begin
      pending_cnt <= PW'(occ_nxt[0]) + PW'(occ_nxt[1]);
    end
  end

  // The set follows the registered write, so the bit rises one edge
  // after commit_wr_en.  A same-edge allocation of that register wins.
  always_comb begin
    rdy_nxt = rdy_map;
    if (commit_wr_en) rdy_nxt[wr_commit_reg] = 1'b1;
    if (alloc_en)     rdy_nxt[alloc_reg]     = 1'b0;
    rdy_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_map <= '1;
    end else begin
      rdy_map <= rdy_nxt;
    end
  end

  assign query_rdy1 = rdy_map[query_reg1];
  assign query_rdy2 = rdy_map[query_reg2];

endmodule

// File: tb/tb_phy_regfile_wb_arbiter.sv
// tb_phy_regfile_wb_arbiter: scoreboard bench for the writeback
// arbiter; expected commits are queued on acceptance.
module tb_phy_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int VW    = 32;
  localparam int PW    = 6;
  localparam int CW    = $clog2(2*DEPTH+1);

  typedef struct packed {
    logic [PW-1:0] r;
    logic [VW-1:0] v;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fu0_valid = 1'b0, fu1_valid = 1'b0;
  logic          fu0_ready, fu1_ready;
  logic [PW-1:0] fu0_dst_reg = '0, fu1_dst_reg = '0;
  logic [VW-1:0] fu0_val = '0, fu1_val = '0;
  logic          fu0_reg_wb = 1'b0, fu1_reg_wb = 1'b0;
  logic          alloc_en = 1'b0;
  logic [PW-1:0] alloc_reg = '0;
  logic [PW-1:0] query_reg1 = '0, query_reg2 = '0;
  logic          query_rdy1, query_rdy2;
  logic          commit_wr_en;
  logic [PW-1:0] wr_commit_reg;
  logic [VW-1:0] commit_wr_val;
  logic [CW-1:0] pending_cnt;

  always #5 clk = ~clk;

  phy_regfile_wb_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .VAL_WIDTH (VW),
    .PREG_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fu0_valid    (fu0_valid),
    .fu0_ready    (fu0_ready),
    .fu0_dst_reg  (fu0_dst_reg),
    .fu0_val      (fu0_val),
    .fu0_reg_wb   (fu0_reg_wb),
    .fu1_valid    (fu1_valid),
    .fu1_ready    (fu1_ready),
    .fu1_dst_reg  (fu1_dst_reg),
    .fu1_val      (fu1_val),
    .fu1_reg_wb   (fu1_reg_wb),
    .alloc_en     (alloc_en),
    .alloc_reg    (alloc_reg),
    .query_reg1   (query_reg1),
    .query_reg2   (query_reg2),
    .query_rdy1   (query_rdy1),
    .query_rdy2   (query_rdy2),
    .commit_wr_en (commit_wr_en),
    .wr_commit_reg(wr_commit_reg),
    .commit_wr_val(commit_wr_val),
    .pending_cnt  (pending_cnt)
  );

  int   vectors = 0;
  int   miscompares = 0;
  ent_t exp0[$];
  ent_t exp1[$];
  ent_t log_q[$];
  int   log_cyc[$];
  int   occ0 = 0, occ1 = 0;
  int   cyc = 0, low0 = 0;
  bit   mon_en = 0, rst_prev = 0, acc0 = 0, acc1 = 0;
  ent_t pend0, pend1;

  // Negedge monitor: scoreboard for commits plus an occupancy model
  // that predicts fuN_ready from accepts and observed pops.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t got;
      cyc++;
      if (rst_prev) begin
        exp0.delete(); exp1.delete();
        occ0 = 0; occ1 = 0;
      end else begin
        if (acc0) begin exp0.push_back(pend0); occ0++; end
        if (acc1) begin exp1.push_back(pend1); occ1++; end
      end
      if (commit_wr_en === 1'b1) begin
        got = {wr_commit_reg, commit_wr_val};
        vectors++;
        log_q.push_back(got);
        log_cyc.push_back(cyc);
        if (exp0.size() > 0 && exp0[0] === got) begin
          void'(exp0.pop_front()); occ0--;
        end else if (exp1.size() > 0 && exp1[0] === got) begin
          void'(exp1.pop_front()); occ1--;
        end else begin
          miscompares++;
          $display("FAIL commit: got reg %0d val %h, want head of a unit queue (sizes %0d/%0d)",
                   wr_commit_reg, commit_wr_val, exp0.size(), exp1.size());
        end
      end
      vectors++;
      if (fu0_ready !== (occ0 < DEPTH)) begin
        miscompares++;
        $display("FAIL fu0_ready: got %b want %b (occ %0d)", fu0_ready, occ0 < DEPTH, occ0);
      end
      vectors++;
      if (fu1_ready !== (occ1 < DEPTH)) begin
        miscompares++;
        $display("FAIL fu1_ready: got %b want %b (occ %0d)", fu1_ready, occ1 < DEPTH, occ1);
      end
      if (fu0_ready === 1'b0) low0++;
      acc0 = !reset && fu0_valid && fu0_ready && fu0_reg_wb && (fu0_dst_reg != '0);
      acc1 = !reset && fu1_valid && fu1_ready && fu1_reg_wb && (fu1_dst_reg != '0);
      pend0 = {fu0_dst_reg, fu0_val};
      pend1 = {fu1_dst_reg, fu1_val};
      rst_prev = reset;
    end
  end

  task automatic drive(input int u, input logic vld, input logic [PW-1:0] d,
                       input logic [VW-1:0] v, input logic wb);
    if (u == 0) begin
      fu0_valid = vld; fu0_dst_reg = d; fu0_val = v; fu0_reg_wb = wb;
    end else begin
      fu1_valid = vld; fu1_dst_reg = d; fu1_val = v; fu1_reg_wb = wb;
    end
  endtask

  task automatic send(input int u, input logic [PW-1:0] d, input logic wb);
    logic [VW-1:0] v;
    int t;
    v = (u == 0) ? (32'hA000_0000 | 32'(d)) : (32'hB000_0000 | 32'(d));
    drive(u, 1'b1, d, v, wb);
    t = 0;
    forever begin
      @(negedge clk);
      if ((u == 0 && fu0_ready) || (u == 1 && fu1_ready)) break;
      t++;
      if (t > 64) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: unit %0d ready got 0, want 1 within 64 cycles", u);
        break;
      end
    end
    @(posedge clk); #1;
    drive(u, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    alloc_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    query_reg1 = 5; query_reg2 = 0; #1;
    vectors++; if (query_rdy1 !== 1'b1) begin miscompares++; $display("FAIL reset_rdy1: got %b want 1", query_rdy1); end
    vectors++; if (query_rdy2 !== 1'b1) begin miscompares++; $display("FAIL reset_rdy2: got %b want 1", query_rdy2); end
    vectors++; if (commit_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", commit_wr_en); end
    vectors++; if (wr_commit_reg !== '0) begin miscompares++; $display("FAIL reset_wr_reg: got %0d want 0", wr_commit_reg); end
    vectors++; if (commit_wr_val !== '0) begin miscompares++; $display("FAIL reset_wr_val: got %h want 0", commit_wr_val); end
    vectors++; if (fu0_ready !== 1'b1) begin miscompares++; $display("FAIL reset_fu0_ready: got %b want 1", fu0_ready); end
    vectors++; if (fu1_ready !== 1'b1) begin miscompares++; $display("FAIL reset_fu1_ready: got %b want 1", fu1_ready); end
    vectors++; if (pending_cnt !== '0) begin miscompares++; $display("FAIL reset_pending: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    alloc_en = 1'b1; alloc_reg = 7; query_reg1 = 7;
    @(posedge clk); #1;
    alloc_en = 1'b0;
    vectors++; if (query_rdy1 !== 1'b0) begin miscompares++; $display("FAIL lat_alloc_rdy: got %b want 0", query_rdy1); end
    drive(0, 1'b1, 7, 32'hDEAD, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    vectors++; if (commit_wr_en !== 1'b0) begin miscompares++; $display("FAIL lat_e0_wr_en: got %b want 0", commit_wr_en); end
    @(posedge clk); #1;
    vectors++; if (commit_wr_en !== 1'b1) begin miscompares++; $display("FAIL lat_e1_wr_en: got %b want 1", commit_wr_en); end
    vectors++; if (wr_commit_reg !== 7) begin miscompares++; $display("FAIL lat_e1_reg: got %0d want 7", wr_commit_reg); end
    vectors++; if (commit_wr_val !== 32'hDEAD) begin miscompares++; $display("FAIL lat_e1_val: got %h want dead", commit_wr_val); end
    vectors++; if (query_rdy1 !== 1'b0) begin miscompares++; $display("FAIL lat_e1_rdy: got %b want 0", query_rdy1); end
    @(posedge clk); #1;
    vectors++; if (query_rdy1 !== 1'b1) begin miscompares++; $display("FAIL lat_e2_rdy: got %b want 1", query_rdy1); end
    vectors++; if (commit_wr_en !== 1'b0) begin miscompares++; $display("FAIL lat_e2_wr_en: got %b want 0", commit_wr_en); end
  endtask

  task automatic test_round_robin();
    int order[6] = '{10, 20, 11, 21, 12, 22};
    apply_reset();
    log_q.delete(); log_cyc.delete();
    fork
      begin send(0, 10, 1'b1); send(0, 11, 1'b1); send(0, 12, 1'b1); end
      begin send(1, 20, 1'b1); send(1, 21, 1'b1); send(1, 22, 1'b1); end
    join
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (log_q.size() != 6) begin
      miscompares++;
      $display("FAIL rr_count: got %0d commits want 6", log_q.size());
    end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      vectors++;
      if (log_q[i].r !== PW'(order[i])) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got reg %0d want %0d", i, log_q[i].r, order[i]);
      end
      vectors++;
      if (log_cyc[i] != log_cyc[0] + i) begin
        miscompares++;
        $display("FAIL rr_back_to_back[%0d]: got cycle %0d want %0d", i, log_cyc[i], log_cyc[0] + i);
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    log_q.delete(); log_cyc.delete();
    low0 = 0;
    fork
      for (int k = 0; k < 10; k++) send(0, PW'(40 + k), 1'b1);
      for (int k = 0; k < 10; k++) send(1, PW'(50 + k), 1'b1);
    join
    for (int i = 0; i < 100 && (exp0.size() + exp1.size() + occ0 + occ1) != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (low0 == 0) begin miscompares++; $display("FAIL full_ready_drop: got 0 low cycles want >0"); end
    vectors++; if (log_q.size() != 20) begin miscompares++; $display("FAIL full_count: got %0d commits want 20", log_q.size()); end
    vectors++; if (exp0.size() + exp1.size() != 0) begin miscompares++; $display("FAIL full_drain: got %0d left want 0", exp0.size() + exp1.size()); end
    vectors++; if (pending_cnt !== '0) begin miscompares++; $display("FAIL full_pending: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_same_edge();
    query_reg1 = 9;
    send(0, 9, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (commit_wr_en !== 1'b1 || wr_commit_reg !== 9) begin
      miscompares++;
      $display("FAIL same_commit: got en %b reg %0d want en 1 reg 9", commit_wr_en, wr_commit_reg);
    end
    alloc_en = 1'b1; alloc_reg = 9;
    @(posedge clk); #1;
    alloc_en = 1'b0;
    vectors++; if (query_rdy1 !== 1'b0) begin miscompares++; $display("FAIL same_clear_wins: got %b want 0", query_rdy1); end
    @(posedge clk); #1;
    vectors++; if (query_rdy1 !== 1'b0) begin miscompares++; $display("FAIL same_clear_hold: got %b want 0", query_rdy1); end
  endtask

  task automatic test_discard();
    log_q.delete(); log_cyc.delete();
    send(0, 12, 1'b0);
    send(1, 0, 1'b1);
    send(0, 0, 1'b0);
    send(1, 13, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (log_q.size() != 0) begin miscompares++; $display("FAIL discard_commits: got %0d want 0", log_q.size()); end
    vectors++; if (pending_cnt !== '0) begin miscompares++; $display("FAIL discard_pending: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    alloc_en = 1'b1; alloc_reg = 33; query_reg2 = 33;
    @(posedge clk); #1;
    alloc_en = 1'b0;
    vectors++; if (query_rdy2 !== 1'b0) begin miscompares++; $display("FAIL mid_alloc_rdy: got %b want 0", query_rdy2); end
    drive(0, 1'b1, 40, 32'h40, 1'b1);
    drive(1, 1'b1, 50, 32'h50, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b1, 41, 32'h41, 1'b1);
    drive(1, 1'b1, 51, 32'h51, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (pending_cnt !== '0) begin miscompares++; $display("FAIL mid_pending: got %0d want 0", pending_cnt); end
    vectors++; if (commit_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_wr_en: got %b want 0", commit_wr_en); end
    vectors++; if (wr_commit_reg !== '0) begin miscompares++; $display("FAIL mid_wr_reg: got %0d want 0", wr_commit_reg); end
    vectors++; if (query_rdy2 !== 1'b1) begin miscompares++; $display("FAIL mid_rdy_reset: got %b want 1", query_rdy2); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (commit_wr_en !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_commit[%0d]: got %b want 0", i, commit_wr_en);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    test_reset();
    test_latency();
    test_round_robin();
    test_full();
    test_same_edge();
    test_discard();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp0.size() + exp1.size() != 0) begin
      miscompares++;
      $display("FAIL end_drain: got %0d queued want 0", exp0.size() + exp1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
